// File: rtl/wb_regfile_demux.sv
// Write-back destination decoder and 32-entry register file.
// The 5-bit destination number from the rt/rd select mux is decoded into
// one-hot write enables (entry 0 never enabled), which update a register
// file with two combinational operand read ports, one synchronous write
// port and one combinational debug read port. Commit tracking outputs
// (wr_onehot, wr_cnt) report the most recent committed write and a
// wrapping count of committed writes.
//
// Handshake: there is no back-pressure. A write is offered by holding
// we=1 with wa/wd stable across a rising edge; it is always accepted on
// that edge unless rst=1 (reset wins) or wa=0 (discarded, not committed).
module wb_regfile_demux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [ADDR_W-1:0]        ra_a,
  input  logic [ADDR_W-1:0]        ra_b,
  output logic [DATA_W-1:0]        rd_a,
  output logic [DATA_W-1:0]        rd_b,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic [(1<<ADDR_W)-1:0]   wr_onehot,
  output logic [15:0]              wr_cnt
);

  localparam int N = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [N];
  logic [N-1:0]      en;
  logic              commit;
  logic              fwd_ok;

  // One-hot write decode; en[0] stays 0 so register 0 is never written.
  // ANDing with we keeps an unknown wa harmless while we=0.
  always_comb begin
    en = '0;
    for (int i = 1; i < N; i++) begin
      en[i] = we & (wa == ADDR_W'(i));
    end
  end

  assign commit = |en;

  // Forwarding is only legal for a write that will actually commit.
  assign fwd_ok = BYPASS && commit && !rst;

  // Register array and commit tracking; reset beats a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        regs[i] <= '0;
      end
      wr_onehot <= '0;
      wr_cnt    <= '0;
    end else begin
      for (int i = 1; i < N; i++) begin
        if (en[i]) regs[i] <= wd;
      end
      if (commit) begin
        wr_onehot <= en;
        wr_cnt    <= wr_cnt + 16'd1;
      end
    end
  end

  // Operand port A: zero register, stored value, or write-first forward.
  always_comb begin
    rd_a = (ra_a == '0) ? '0 : regs[ra_a];
    if (fwd_ok && (wa == ra_a)) rd_a = wd;
  end

  // Operand port B: same rules as port A, evaluated independently.
  always_comb begin
    rd_b = (ra_b == '0) ? '0 : regs[ra_b];
    if (fwd_ok && (wa == ra_b)) rd_b = wd;
  end

  // Debug port always shows the stored contents, never the in-flight write.
  always_comb begin
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: tb/tb_wb_regfile_demux.sv
// Directed bench for wb_regfile_demux. Two instances share all inputs:
// dut with forwarding enabled, dut_nb with forwarding disabled.
`timescale 1ns/1ps
module tb_wb_regfile_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra_a;
  logic [4:0]  ra_b;
  logic [4:0]  dbg_addr;
  logic [31:0] rd_a, rd_b, dbg_data;
  logic [31:0] rd_a_nb, rd_b_nb, dbg_data_nb;
  logic [31:0] wr_onehot, wr_onehot_nb;
  logic [15:0] wr_cnt, wr_cnt_nb;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra_a;
    logic [4:0]  ra_b;
    logic [4:0]  dbg;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_a_nb;
    logic [31:0] exp_b_nb;
    logic [31:0] exp_dbg;
    logic [31:0] exp_oh;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [14];

  wb_regfile_demux #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a), .rd_b(rd_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wr_onehot(wr_onehot), .wr_cnt(wr_cnt)
  );

  wb_regfile_demux #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a_nb), .rd_b(rd_b_nb),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb),
    .wr_onehot(wr_onehot_nb), .wr_cnt(wr_cnt_nb)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] xa, input logic [4:0] xb, input logic [4:0] xd);
    rst = r; we = w; wa = a; wd = d; ra_a = xa; ra_b = xb; dbg_addr = xd;
  endtask

  // Apply inputs just after a rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic r, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [4:0] xa, input logic [4:0] xb,
                         input logic [4:0] xd, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ea_nb, input logic [31:0] eb_nb,
                         input logic [31:0] edbg, input logic [31:0] eoh, input logic [15:0] ecnt);
    vecs[i] = '{r, w, a, d, xa, xb, xd, ea, eb, ea_nb, eb_nb, edbg, eoh, ecnt};
  endtask

  initial begin
    // Vectors: outputs expected in the cycle the inputs are applied,
    // i.e. state from earlier edges plus same-cycle forwarding.
    //        rst we  wa     wd            ra_a ra_b dbg  exp_a         exp_b         exp_a_nb      exp_b_nb      exp_dbg       exp_oh        cnt
    set_vec(0,  0, 1, 5'd5,  32'hDEADBEEF, 5,   0,   5,   32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0);
    set_vec(1,  0, 0, 5'd0,  32'h0,        5,   5,   5,   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h20,       1);
    set_vec(2,  0, 1, 5'd0,  32'h12345678, 0,   5,   0,   32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        32'h20,       1);
    set_vec(3,  0, 0, 5'd0,  32'h0,        0,   0,   0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h20,       1);
    set_vec(4,  0, 1, 5'd31, 32'hA5A5A5A5, 31,  1,   31,  32'hA5A5A5A5, 32'h0,        32'h0,        32'h0,        32'h0,        32'h20,       1);
    set_vec(5,  0, 1, 5'd1,  32'h5A5A5A5A, 31,  1,   1,   32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0,        32'h0,        32'h80000000, 2);
    set_vec(6,  0, 0, 5'd0,  32'h0,        31,  1,   1,   32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h2,        3);
    set_vec(7,  0, 1, 5'd9,  32'h0BADF00D, 9,   9,   9,   32'h0BADF00D, 32'h0BADF00D, 32'h0,        32'h0,        32'h0,        32'h2,        3);
    set_vec(8,  0, 1, 5'd9,  32'h11112222, 9,   0,   9,   32'h11112222, 32'h0,        32'h0BADF00D, 32'h0,        32'h0BADF00D, 32'h200,      4);
    set_vec(9,  0, 0, 5'd9,  32'h0,        9,   9,   9,   32'h11112222, 32'h11112222, 32'h11112222, 32'h11112222, 32'h11112222, 32'h200,      5);
    set_vec(10, 0, 0, 5'bx,  32'hFFFFFFFF, 5,   31,  9,   32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h11112222, 32'h200,      5);
    set_vec(11, 1, 1, 5'd7,  32'hFFFFFFFF, 7,   5,   7,   32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        32'h200,      5);
    set_vec(12, 0, 0, 5'd0,  32'h0,        7,   5,   31,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0);
    set_vec(13, 0, 1, 5'd4,  32'h00000044, 3,   4,   4,   32'h0,        32'h00000044, 32'h0,        32'h0,        32'h0,        32'h0,        0);

    // Reset sequence.
    drive(1, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // After reset every address reads zero on every port.
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a++) begin
      ra_a = 5'(a); ra_b = 5'(a); dbg_addr = 5'(a);
      #1;
      check($sformatf("reset_rd_a[%0d]", a), rd_a, 32'h0);
      check($sformatf("reset_rd_b[%0d]", a), rd_b, 32'h0);
      check($sformatf("reset_dbg[%0d]", a), dbg_data, 32'h0);
    end
    check("reset_onehot", wr_onehot, 32'h0);
    check("reset_cnt", {16'h0, wr_cnt}, 32'h0);

    // Table vectors.
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].ra_a, vecs[i].ra_b, vecs[i].dbg);
      @(negedge clk);
      check($sformatf("v%0d_rd_a", i), rd_a, vecs[i].exp_a);
      check($sformatf("v%0d_rd_b", i), rd_b, vecs[i].exp_b);
      check($sformatf("v%0d_rd_a_nb", i), rd_a_nb, vecs[i].exp_a_nb);
      check($sformatf("v%0d_rd_b_nb", i), rd_b_nb, vecs[i].exp_b_nb);
      check($sformatf("v%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
      check($sformatf("v%0d_dbg_nb", i), dbg_data_nb, vecs[i].exp_dbg);
      check($sformatf("v%0d_onehot", i), wr_onehot, vecs[i].exp_oh);
      check($sformatf("v%0d_cnt", i), {16'h0, wr_cnt}, {16'h0, vecs[i].exp_cnt});
    end

    // Last vector committed reg4=0x44.
    next_cycle();
    drive(0, 0, 0, 0, 4, 4, 4);
    @(negedge clk);
    check("post_v13_rd_a", rd_a, 32'h44);
    check("post_v13_dbg", dbg_data, 32'h44);
    check("post_v13_onehot", wr_onehot, 32'h10);
    check("post_v13_cnt", {16'h0, wr_cnt}, 32'h1);

    // Counter wrap: reset, then 65537 writes to reg3 with wd = write index.
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0);
    next_cycle();
    for (int n = 0; n < 65535; n++) begin
      drive(0, 1, 3, 32'(n), 3, 3, 3);
      next_cycle();
    end
    drive(0, 0, 0, 0, 3, 3, 3);
    @(negedge clk);
    check("wrap_cnt_ffff", {16'h0, wr_cnt}, 32'h0000FFFF);
    check("wrap_reg3_ffff", dbg_data, 32'd65534);
    next_cycle();
    drive(0, 1, 3, 32'd65535, 3, 3, 3);
    next_cycle();
    drive(0, 0, 0, 0, 3, 3, 3);
    @(negedge clk);
    check("wrap_cnt_0000", {16'h0, wr_cnt}, 32'h0);
    next_cycle();
    drive(0, 1, 3, 32'hCAFEF00D, 3, 3, 3);
    next_cycle();
    drive(0, 0, 0, 0, 3, 3, 3);
    @(negedge clk);
    check("wrap_cnt_0001", {16'h0, wr_cnt}, 32'h1);
    check("wrap_reg3_rd_a", rd_a, 32'hCAFEF00D);
    check("wrap_reg3_dbg", dbg_data, 32'hCAFEF00D);
    check("wrap_onehot", wr_onehot, 32'h8);
    check("wrap_cnt_nb", {16'h0, wr_cnt_nb}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile_demux.md
Name: wb_regfile_demux

Overview:
- Write-back end of the destination-register select path: takes the 5-bit destination number produced by the rt/rd select mux and decodes it into one-hot write enables.
- Decoded enables drive a 32-entry register file (2 async read ports, 1 sync write port, 1 debug read port).
- Sits between the WB stage and the ID-stage operand read; register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of every data port.
- ADDR_W, 5, register address width; entry count is 2^ADDR_W. Only 5 is supported.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = a read returns the pre-write value.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write-back valid; a write is performed this edge when we=1.
- wa  in  ADDR_W  destination register number (output of the rt/rd select mux).
- wd  in  DATA_W  write-back data.
- ra_a  in  ADDR_W  read address, port A (rs).
- ra_b  in  ADDR_W  read address, port B (rt).
- rd_a  out  DATA_W  read data, port A, combinational.
- rd_b  out  DATA_W  read data, port B, combinational.
- dbg_addr  in  ADDR_W  debug/display read address.
- dbg_data  out  DATA_W  debug read data, combinational, never bypassed.
- wr_onehot  out  2^ADDR_W  registered one-hot of the last committed write; all zeros if none.
- wr_cnt  out  16  registered count of committed writes; wraps.

Behaviour:
- Decode: en[i] = we & (wa==i) for i in 1..31; en[0] is always 0.
  - Writes to register 0 are discarded: no array change, no wr_onehot update, no wr_cnt increment.
- Write timing: on a rising edge with rst=0 and en[i]=1, reg[i] <= wd. Visible on all read ports from the next cycle; latency is 1 edge.
- Reset: on a rising edge with rst=1, all 32 registers <= 0, wr_onehot <= 0, wr_cnt <= 0.
  - Reset takes priority over a simultaneous write; that write is lost.
  - Outputs are undefined before the first reset edge.
- Reads: rd_x = (ra_x==0) ? 0 : reg[ra_x].
  - With BYPASS=1: if we=1, wa!=0, wa==ra_x and rst=0, then rd_x = wd (write-first).
  - Port A and port B bypass independently; both may hit the same address.
- Debug port: dbg_data = reg[dbg_addr], or 0 for address 0. Never bypassed.
- wr_onehot: on each committed write, <= (1<<wa). Otherwise holds its value.
- wr_cnt: on each committed write, <= wr_cnt+1, mod 2^16. Ends at 0x0000 after 0xFFFF.
- Back-to-back writes to the same register: the last edge wins; each write counts separately.
- X-free: unknown wa with we=0 must not corrupt the array.

Test Plan:
- Reset, then read all 32 addresses on A, B and dbg -> all read 0; wr_onehot=0; wr_cnt=0.
- we=1, wa=5, wd=0xDEADBEEF, ra_a=5 in the same cycle:
  - BYPASS=1 -> rd_a=0xDEADBEEF that cycle.
  - BYPASS=0 -> rd_a=0 that cycle, 0xDEADBEEF next cycle.
  - After the edge: dbg_addr=5 reads 0xDEADBEEF, wr_onehot=0x00000020, wr_cnt=1.
- we=1, wa=0, wd=0x12345678 -> rd_a(ra_a=0)=0 in the same and next cycle; wr_onehot and wr_cnt unchanged.
- Write reg31=0xA5A5A5A5 and reg1=0x5A5A5A5A on consecutive edges, ra_a=31, ra_b=1 -> rd_a=0xA5A5A5A5, rd_b=0x5A5A5A5A; wr_onehot=0x00000002; wr_cnt=2.
- rst=1 and we=1, wa=7, wd=0xFFFFFFFF on the same edge -> reg7=0, wr_cnt=0. While rst=1 with BYPASS=1, rd_a(ra_a=7)=0, i.e. no forwarding.
- Perform 65537 writes to reg3 -> wr_cnt=0x0001; reg3 holds the last wd.
